// File: rtl/cond_flags_reg.sv
// cond_flags_reg: architectural condition-flag register with a save/restore stack.
//
// Holds {Z,C,N,V} for the condition checker. Group-wise flag writes are enabled
// by FlagW and qualified by CondEx. Push/Pop save and restore the flag register
// on a small LIFO stack, so interrupt entry and return can preserve the flags.
//
// Parameters:
//   DEPTH      - number of save-stack entries, 1..15
//
// Ports:
//   clk        in  1  rising-edge clock
//   reset      in  1  synchronous active-high reset
//   ALUFlags   in  4  {Z,C,N,V} from the ALU
//   FlagW      in  2  bit1 writes Z/N, bit0 writes C/V
//   CondEx     in  1  condition passed; qualifies FlagW
//   Push       in  1  save flag register onto stack
//   Pop        in  1  restore flag register from stack top
//   Flags      out 4  flags to the condition checker
//   StackDepth out 4  entries currently held
//   StackEmpty out 1  StackDepth == 0
//   StackFull  out 1  StackDepth == DEPTH
//   StackErr   out 1  sticky push-when-full / pop-when-empty
//
// Build option:
//   COND_FLAGS_BYPASS_EN - when defined, Flags shows the current cycle's
//   qualified write merged over the register (except in a restoring Pop cycle).
//   When undefined, Flags is the register output only.

module cond_flags_reg #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondEx,
  input  logic       Push,
  input  logic       Pop,
  output logic [3:0] Flags,
  output logic [3:0] StackDepth,
  output logic       StackEmpty,
  output logic       StackFull,
  output logic       StackErr
);

  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DepthMax = 4'(DEPTH);

  logic [3:0]      fr_q, fr_d;
  logic [3:0]      depth_q, depth_d;
  logic            err_q, err_d;
  logic [3:0]      stack_q [DEPTH];

  logic            wzn, wcv;
  logic [3:0]      wr_mask;
  logic [3:0]      fr_wr;
  logic            empty, full;
  logic            push_req, pop_req;
  logic            do_push, do_pop;
  logic [3:0]      depth_m1;
  logic [IdxW-1:0] push_idx, pop_idx;

  // Qualified group write enables; mask lines up with {Z,C,N,V}.
  assign wzn     = FlagW[1] & CondEx;
  assign wcv     = FlagW[0] & CondEx;
  assign wr_mask = {wzn, wcv, wzn, wcv};
  assign fr_wr   = (fr_q & ~wr_mask) | (ALUFlags & wr_mask);

  assign empty = (depth_q == 4'd0);
  assign full  = (depth_q == DepthMax);

  // Push and Pop together cancel each other: no stack action, no error.
  assign push_req = Push & ~Pop;
  assign pop_req  = Pop & ~Push;
  assign do_push  = push_req & ~full;
  assign do_pop   = pop_req & ~empty;

  assign depth_m1 = depth_q - 4'd1;
  assign push_idx = depth_q[IdxW-1:0];
  assign pop_idx  = depth_m1[IdxW-1:0];

  always_comb begin
    fr_d    = fr_wr;
    depth_d = depth_q;
    err_d   = err_q;
    if (do_push) begin
      depth_d = depth_q + 4'd1;
    end
    if (do_pop) begin
      // Restore wins over any same-cycle flag write, both groups.
      fr_d    = stack_q[pop_idx];
      depth_d = depth_m1;
    end
    if ((push_req && full) || (pop_req && empty)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fr_q    <= 4'b0000;
      depth_q <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      fr_q    <= fr_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack storage is not reset; nothing reads it while the depth is zero.
  // The saved value is the pre-update register, even if a write lands this cycle.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      stack_q[push_idx] <= fr_q;
    end
  end

`ifdef COND_FLAGS_BYPASS_EN
  // A restoring Pop is never bypassed: the restored value appears next cycle.
  assign Flags = do_pop ? fr_q : fr_wr;
`else
  assign Flags = fr_q;
`endif

  assign StackDepth = depth_q;
  assign StackEmpty = empty;
  assign StackFull  = full;
  assign StackErr   = err_q;

endmodule
